sram_obi_bridge: RTL and testbench

- Bus-side front end for the dual-port SRAM's byte-enabled port A. Converts an OBI-style request/grant plus response-valid/ready handshake into single-cycle SRAM accesses.
- Handles the SRAM's one-cycle read latency. Buffers responses in a small FIFO so the core can apply backpressure.
- Flags accesses outside the SRAM window as errors.
- Sits between the core's instruction/data bus and the SRAM.

---
 rtl/sram_obi_bridge.sv | 161 ++++++++++++++++
 tb/tb_sram_obi_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_obi_bridge.sv
// OBI request/grant front end for the byte-enabled SRAM port: one-cycle read latency plus an in-order response FIFO.
// Optional `SRAM_OBI_BRIDGE_PERF_EN adds saturating read/write/error access counters.
module sram_obi_bridge #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRWIDTH    = 14,
  parameter int BUSADDRWIDTH = 32,
  parameter logic [BUSADDRWIDTH-1:0] BASE_ADDR = '0,
  parameter int RSP_DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  output logic                    gnt,
  input  logic [BUSADDRWIDTH-1:0] addr,
  input  logic                    we,
  input  logic [DATAWIDTH/8-1:0]  be,
  input  logic [DATAWIDTH-1:0]    wdata,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATAWIDTH-1:0]    rdata,
  output logic                    err,
  output logic [ADDRWIDTH-1:0]    sram_addr,
  output logic                    sram_we,
  output logic [DATAWIDTH/8-1:0]  sram_be,
  output logic [DATAWIDTH-1:0]    sram_d,
  input  logic [DATAWIDTH-1:0]    sram_q
`ifdef SRAM_OBI_BRIDGE_PERF_EN
  ,
  output logic [31:0]             perf_rd_cnt,
  output logic [31:0]             perf_wr_cnt,
  output logic [31:0]             perf_err_cnt
`endif
);

  localparam int BEW = DATAWIDTH / 8;
  localparam int LSB = $clog2(BEW);
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam logic [BUSADDRWIDTH:0] WINDOW = (BUSADDRWIDTH+1)'(BEW) << ADDRWIDTH;

  typedef struct packed {
    logic                 err;
    logic [DATAWIDTH-1:0] data;
  } rsp_t;

  logic [BUSADDRWIDTH-1:0] off;
  logic                    in_range;
  logic                    accept;
  logic                    pop;
  logic                    push;
  logic                    fifo_pop;
  logic                    fifo_empty;
  rsp_t                    stg_rsp;
  rsp_t                    head;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          stg_vld_q, stg_vld_d;
  logic          stg_rd_q, stg_rd_d;
  logic          stg_err_q, stg_err_d;
  rsp_t          mem_q [RSP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign off       = addr - BASE_ADDR;
  assign in_range  = {1'b0, off} < WINDOW;
  assign gnt       = !rst && (cnt_q < CW'(RSP_DEPTH));
  assign accept    = req && gnt;
  assign sram_addr = off[LSB +: ADDRWIDTH];
  assign sram_we   = accept && we && in_range;
  assign sram_be   = be;
  assign sram_d    = wdata;

  // The stage register holds the response accepted last cycle; read data is taken live from sram_q.
  always_comb begin
    stg_rsp      = '0;
    stg_rsp.err  = stg_err_q;
    stg_rsp.data = stg_rd_q ? sram_q : '0;
  end

  assign fifo_empty = (fcnt_q == '0);
  assign head       = fifo_empty ? stg_rsp : mem_q[rptr_q];
  assign rvalid     = !rst && (!fifo_empty || stg_vld_q);
  assign rdata      = rvalid ? head.data : '0;
  assign err        = rvalid && head.err;
  assign pop        = rvalid && rready;
  assign fifo_pop   = pop && !fifo_empty;
  // A fresh response bypasses the FIFO only when nothing is queued ahead of it and it is consumed now.
  assign push       = stg_vld_q && !(fifo_empty && rready);

  always_comb begin
    cnt_d     = cnt_q + CW'(accept) - CW'(pop);
    fcnt_d    = fcnt_q + CW'(push) - CW'(fifo_pop);
    wptr_d    = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d    = fifo_pop ? ptr_inc(rptr_q) : rptr_q;
    stg_vld_d = accept;
    stg_rd_d  = accept && !we && in_range;
    stg_err_d = accept && !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      fcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      stg_vld_q <= 1'b0;
      stg_rd_q  <= 1'b0;
      stg_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      stg_vld_q <= stg_vld_d;
      stg_rd_q  <= stg_rd_d;
      stg_err_q <= stg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= stg_rsp;
  end

`ifdef SRAM_OBI_BRIDGE_PERF_EN
  logic [31:0] perf_rd_q, perf_rd_d;
  logic [31:0] perf_wr_q, perf_wr_d;
  logic [31:0] perf_err_q, perf_err_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && (c != '1)) ? c + 32'd1 : c;
  endfunction

  always_comb begin
    perf_rd_d  = sat_inc(perf_rd_q, accept && !we && in_range);
    perf_wr_d  = sat_inc(perf_wr_q, accept && we && in_range);
    perf_err_d = sat_inc(perf_err_q, accept && !in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_q  <= '0;
      perf_wr_q  <= '0;
      perf_err_q <= '0;
    end else begin
      perf_rd_q  <= perf_rd_d;
      perf_wr_q  <= perf_wr_d;
      perf_err_q <= perf_err_d;
    end
  end

  assign perf_rd_cnt  = perf_rd_q;
  assign perf_wr_cnt  = perf_wr_q;
  assign perf_err_cnt = perf_err_q;
`endif

endmodule

// File: tb/tb_sram_obi_bridge.sv
// Self-checking bench for sram_obi_bridge: SRAM behavioural model, transaction-level reference queue, directed and random traffic.
module tb_sram_obi_bridge;
  localparam int DW    = 32;
  localparam int AW    = 14;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam longint WIN_BYTES = longint'(BW) << AW;

  // Clock/reset and DUT signals
  logic          clk = 1'b0;
  logic          rst;
  logic          req, gnt, we, rvalid, rready, err, sram_we;
  logic [31:0]   addr, wdata, rdata, sram_d, sram_q;
  logic [3:0]    be, sram_be;
  logic [AW-1:0] sram_addr;
`ifdef SRAM_OBI_BRIDGE_PERF_EN
  logic [31:0]   perf_rd_cnt, perf_wr_cnt, perf_err_cnt;
`endif

  always #5 clk = ~clk;

  sram_obi_bridge #(
    .DATAWIDTH(DW), .ADDRWIDTH(AW), .BUSADDRWIDTH(32), .BASE_ADDR(BASE), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .addr(addr), .we(we), .be(be), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .err(err),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_be(sram_be), .sram_d(sram_d), .sram_q(sram_q)
`ifdef SRAM_OBI_BRIDGE_PERF_EN
    , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_err_cnt(perf_err_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM: registered read of the presented address, byte-masked write
  logic [31:0] sram_mem [0:(1<<AW)-1];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (sram_we)
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_d[b*8 +: 8];
      sram_q <= sram_mem[sram_addr];
    end
  end

  // Reference model: word memory seen from the bus, queue of expected responses in request order
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          avail;
  } rsp_t;

  logic [31:0] ref_mem [0:(1<<AW)-1];
  rsp_t        exp_q[$];
  logic [31:0] got_q[$];
  logic        got_err_q[$];
  int          cyc = 0;
  int          outst = 0;

  initial begin : compare_proc
    logic        exp_gnt, exp_rv, inr;
    longint      off;
    int          word;
    rsp_t        r;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("gnt_in_rst", gnt, 0);
        check("sram_we_in_rst", sram_we, 0);
        check("rvalid_in_rst", rvalid, 0);
        exp_q.delete();
        outst = 0;
      end else begin
        exp_gnt = (outst < DEPTH);
        off     = longint'(addr - BASE);
        inr     = (off < WIN_BYTES);
        word    = int'(off / BW) % (1 << AW);
        check("gnt", gnt, exp_gnt);
        check("sram_we", sram_we, req && exp_gnt && we && inr);
        check("sram_addr", sram_addr, word);
        check("sram_be", sram_be, be);
        check("sram_d", sram_d, wdata);
        exp_rv = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        check("rvalid", rvalid, exp_rv);
        if (exp_rv) begin
          check("rdata", rdata, exp_q[0].data);
          check("err", err, exp_q[0].err);
          if (rready) begin
            got_q.push_back(rdata);
            got_err_q.push_back(err);
            void'(exp_q.pop_front());
            outst--;
          end
        end
        if (req && exp_gnt) begin
          r.err   = !inr;
          r.data  = 32'h0;
          r.avail = cyc + 1;
          if (inr && !we) r.data = ref_mem[word];
          if (inr && we)
            for (int b = 0; b < BW; b++)
              if (be[b]) ref_mem[word][b*8 +: 8] = wdata[b*8 +: 8];
          exp_q.push_back(r);
          outst++;
        end
      end
    end
  end

  // Driver: caller sits just after a posedge; returns just after the accepting posedge with req dropped
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                       output logic we_seen, output logic [AW-1:0] sa_seen);
    int n;
    n = 0;
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    @(negedge clk);
    while (!gnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("issue_grant", gnt, 1);
    we_seen = sram_we;
    sa_seen = sram_addr;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : timeout_proc
    #2_000_000;
    $display("FAIL global_timeout cycles=%0d required=finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin : main_proc
    logic          ws;
    logic [AW-1:0] sa;
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", rdata, 0);
    check("reset_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("gnt_after_reset", gnt, 1);
    @(posedge clk); #1;

    // Write then read back, one-cycle read latency
    issue(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, ws, sa);
    check("t1_we_pulse", ws, 1);
    check("t1_sram_addr", sa, 4);
    issue(32'h10, 1'b0, 4'h0, 32'h0, ws, sa);
    check("t1_read_no_we", ws, 0);
    @(negedge clk);
    check("t1_rvalid", rvalid, 1);
    check("t1_rdata", rdata, 32'hDEAD_BEEF);
    check("t1_err", err, 0);
    @(posedge clk); #1;

    // Partial byte write
    issue(32'h20, 1'b1, 4'hF, 32'h1122_3344, ws, sa);
    issue(32'h20, 1'b1, 4'b0010, 32'hAABB_CCDD, ws, sa);
    issue(32'h20, 1'b0, 4'h0, 32'h0, ws, sa);
    @(negedge clk);
    check("t2_rdata", rdata, 32'h1122_CC44);
    @(posedge clk); #1;
    idle(3);

    // Backpressure: two accepts then grant drops until the first pop
    issue(32'h0, 1'b1, 4'hF, 32'hA, ws, sa);
    issue(32'h4, 1'b1, 4'hF, 32'hB, ws, sa);
    issue(32'h8, 1'b1, 4'hF, 32'hC, ws, sa);
    idle(3);
    got_q.delete();
    rready = 1'b0;
    issue(32'h0, 1'b0, 4'h0, 32'h0, ws, sa);
    issue(32'h4, 1'b0, 4'h0, 32'h0, ws, sa);
    req = 1'b1; addr = 32'h8; we = 1'b0;
    @(negedge clk);
    check("t3_gnt_low_a", gnt, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_gnt_low_b", gnt, 0);
    @(posedge clk); #1;
    rready = 1'b1;
    @(negedge clk);
    check("t3_gnt_low_at_pop", gnt, 0);
    check("t3_head", rdata, 32'hA);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_gnt_back", gnt, 1);
    @(posedge clk); #1;
    idle(5);
    check("t3_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t3_order0", got_q[0], 32'hA);
      check("t3_order1", got_q[1], 32'hB);
      check("t3_order2", got_q[2], 32'hC);
    end

    // Out-of-range access, then in-range read
    issue(32'h0001_0000, 1'b1, 4'hF, 32'hFFFF_FFFF, ws, sa);
    check("t4_oor_no_we", ws, 0);
    @(negedge clk);
    check("t4_rvalid", rvalid, 1);
    check("t4_err", err, 1);
    check("t4_rdata", rdata, 0);
    @(posedge clk); #1;
    issue(32'h10, 1'b0, 4'h0, 32'h0, ws, sa);
    @(negedge clk);
    check("t4_after_rdata", rdata, 32'hDEAD_BEEF);
    check("t4_after_err", err, 0);
    @(posedge clk); #1;
    issue(32'h0000_FFFC, 1'b1, 4'hF, 32'h0BAD_F00D, ws, sa);
    check("t4_last_word_we", ws, 1);
    check("t4_last_word_addr", sa, 14'h3FFF);
    idle(3);

    // Reset with two responses buffered
    got_q.delete();
    rready = 1'b0;
    issue(32'h0, 1'b0, 4'h0, 32'h0, ws, sa);
    issue(32'h4, 1'b0, 4'h0, 32'h0, ws, sa);
    @(negedge clk);
    check("t5_buffered", rvalid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    check("t5_rvalid_cleared", rvalid, 0);
    check("t5_gnt", gnt, 1);
    @(posedge clk); #1;
    idle(4);
    check("t5_no_stale", got_q.size(), 0);

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'h0001_0000 + ($urandom_range(0, 255) << 2);
        1:       addr = $urandom();
        2:       addr = 32'h0000_FFFC | $urandom_range(0, 3);
        default: addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      endcase
      req    = ($urandom_range(0, 3) != 0);
      we     = $urandom_range(0, 1);
      be     = 4'($urandom_range(0, 15));
      wdata  = $urandom();
      rready = ($urandom_range(0, 2) != 0);
      rst    = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    rready = 1'b1;
    idle(10);
    check("drain_empty", exp_q.size(), 0);

`ifdef SRAM_OBI_BRIDGE_PERF_EN
    pulse_rst();
    issue(32'h0, 1'b0, 4'h0, 32'h0, ws, sa);
    issue(32'h4, 1'b0, 4'h0, 32'h0, ws, sa);
    issue(32'h8, 1'b0, 4'h0, 32'h0, ws, sa);
    issue(32'h40, 1'b1, 4'hF, 32'h1, ws, sa);
    issue(32'h44, 1'b1, 4'h0, 32'h2, ws, sa);
    issue(32'h0002_0000, 1'b0, 4'h0, 32'h0, ws, sa);
    idle(3);
    @(negedge clk);
    check("perf_rd", perf_rd_cnt, 3);
    check("perf_wr", perf_wr_cnt, 2);
    check("perf_err", perf_err_cnt, 1);
    @(posedge clk); #1;
    pulse_rst();
    @(negedge clk);
    check("perf_rd_rst", perf_rd_cnt, 0);
    check("perf_wr_rst", perf_wr_cnt, 0);
    check("perf_err_rst", perf_err_cnt, 0);
`else
    pulse_rst();
    idle(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
